ysyx_23060025_clint: RTL and testbench

//   AXI-lite read responder for the core-local timer (CLINT) on the read-only CLINT branch of the xbar.

---
 rtl/ysyx_23060025_clint.sv | 157 +++++++++++++++
 tb/tb_ysyx_23060025_clint.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_clint.sv
// ysyx_23060025_clint -- core-local timer (CLINT) read responder.
//
// Purpose:
//   Sits on the read-only CLINT branch of the xbar. It holds a free-running
//   64-bit mtime counter and answers single-beat 32-bit AXI-lite reads.
//   mtime is returned as two words. Reading the low word latches the high
//   word into hi_shadow. A later high-word read returns that shadow, so
//   software sees a coherent 64-bit value across the two reads.
//
// Ports:
//   clock           in   single clock, all state on posedge
//   rstn            in   asynchronous active-low reset
//   addr_r_addr_i   in   read address from xbar
//   addr_r_valid_i  in   read address valid
//   addr_r_ready_o  out  responder can accept an address
//   r_data_o        out  read data (mtime snapshot, hi_shadow or 0)
//   r_valid_o       out  read data valid
//   r_last_o        out  last beat, always equal to r_valid_o
//   r_ready_i       in   master accepts read data
//   dbg_state_o     out  current FSM state (0 = IDLE, 1 = RESP)
//
// Handshake semantics:
//   A transfer happens on a posedge where valid && ready are both high.
//   Once r_valid_o is raised, r_data_o, r_valid_o and r_last_o hold until
//   r_ready_i is seen. The address channel is not ready while a response
//   is pending, so addresses presented then are ignored.
//
// Configuration:
//   CLINT_PRESCALE_EN  when defined, mtime advances once every DIV clocks.
//                      A $clog2(DIV)-bit prescale counter drives the tick.
//                      DIV must be >= 1.
//                      When undefined, mtime advances every clock and DIV
//                      is ignored.

module ysyx_23060025_clint #(
  parameter int                  ADDR_LEN   = 32,
  parameter int                  DATA_LEN   = 32,
  parameter logic [ADDR_LEN-1:0] MTIME_ADDR = 32'h0200_BFF8,
  parameter int                  DIV        = 1
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic [ADDR_LEN-1:0] addr_r_addr_i,
  input  logic                addr_r_valid_i,
  output logic                addr_r_ready_o,
  output logic [DATA_LEN-1:0] r_data_o,
  output logic                r_valid_o,
  output logic                r_last_o,
  input  logic                r_ready_i,
  output logic                dbg_state_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  localparam logic [ADDR_LEN-1:0] MTIME_HI_ADDR = MTIME_ADDR + 4;

  logic [0:0]          state;
  logic [63:0]         mtime;
  logic [31:0]         hi_shadow;
  logic                tick;
  logic [DATA_LEN-1:0] rd_sel;
  logic                is_lo;

  assign dbg_state_o = state;

`ifdef CLINT_PRESCALE_EN
  // A width of at least one bit keeps DIV=1 legal.
  // In that case the counter sits at 0 and mtime ticks every clock.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0] pre_cnt;

  if (DIV < 1) begin : g_div_check
    $error("ysyx_23060025_clint: DIV must be >= 1");
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_MAX) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign tick = (pre_cnt == PRE_MAX);
`else
  // DIV has no effect without the prescaler.
  if (DIV < 1) begin : g_div_unused
  end

  assign tick = 1'b1;
`endif

  // Full-width address compare.
  // Unaligned or unmapped addresses fall through to zero.
  assign is_lo = (addr_r_addr_i == MTIME_ADDR);

  always_comb begin
    rd_sel = '0;
    if (is_lo) begin
      rd_sel = DATA_LEN'(mtime[31:0]);
    end else if (addr_r_addr_i == MTIME_HI_ADDR) begin
      rd_sel = DATA_LEN'(hi_shadow);
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      mtime          <= '0;
      hi_shadow      <= '0;
      r_data_o       <= '0;
      r_valid_o      <= 1'b0;
      r_last_o       <= 1'b0;
      addr_r_ready_o <= 1'b0;
    end else begin
      // mtime keeps counting through backpressure.
      // Returned data is the value captured at the address handshake.
      mtime <= mtime + {63'd0, tick};

      case (state)
        IDLE: begin
          addr_r_ready_o <= 1'b1;
          if (addr_r_valid_i && addr_r_ready_o) begin
            state          <= RESP;
            addr_r_ready_o <= 1'b0;
            r_valid_o      <= 1'b1;
            r_last_o       <= 1'b1;
            r_data_o       <= rd_sel;
            if (is_lo) begin
              hi_shadow <= mtime[63:32];
            end
          end
        end
        RESP: begin
          if (r_ready_i) begin
            state          <= IDLE;
            r_valid_o      <= 1'b0;
            r_last_o       <= 1'b0;
            addr_r_ready_o <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          r_valid_o      <= 1'b0;
          r_last_o       <= 1'b0;
          addr_r_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_clint.sv
// Directed testbench for ysyx_23060025_clint.
// Inputs are driven on the falling edge.
// Outputs are sampled on the falling edge or 1 time unit after a rising edge.
// mtime counts rising edges after reset release.
// The handshake captures the count before that edge's increment.
// With CLINT_PRESCALE_EN, DIV=4, so the count is divided by four.

module tb_ysyx_23060025_clint;

  localparam logic [31:0] LO_ADDR = 32'h0200_BFF8;
  localparam logic [31:0] HI_ADDR = 32'h0200_BFFC;

`ifdef CLINT_PRESCALE_EN
  localparam logic [63:0] EXP_AFTER1 = 64'd0;   // 1 edge / 4
  localparam logic [31:0] EXP_T2     = 32'd25;  // 100 edges / 4
  localparam logic [31:0] EXP_T3     = 32'd25;  // 102 edges / 4
  localparam logic [31:0] EXP_T6     = 32'd10;  // 40 edges / 4
`else
  localparam logic [63:0] EXP_AFTER1 = 64'd1;
  localparam logic [31:0] EXP_T2     = 32'd100;
  localparam logic [31:0] EXP_T3     = 32'd102;
  localparam logic [31:0] EXP_T6     = 32'd40;
`endif

  logic        clock;
  logic        rstn;
  logic [31:0] addr_r_addr_i;
  logic        addr_r_valid_i;
  logic        addr_r_ready_o;
  logic [31:0] r_data_o;
  logic        r_valid_o;
  logic        r_last_o;
  logic        r_ready_i;
  logic        dbg_state_o;

  int total = 0;
  int bad   = 0;

  ysyx_23060025_clint #(
    .ADDR_LEN  (32),
    .DATA_LEN  (32),
    .MTIME_ADDR(32'h0200_BFF8),
    .DIV       (4)
  ) dut (
    .clock         (clock),
    .rstn          (rstn),
    .addr_r_addr_i (addr_r_addr_i),
    .addr_r_valid_i(addr_r_valid_i),
    .addr_r_ready_o(addr_r_ready_o),
    .r_data_o      (r_data_o),
    .r_valid_o     (r_valid_o),
    .r_last_o      (r_last_o),
    .r_ready_i     (r_ready_i),
    .dbg_state_o   (dbg_state_o)
  );

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks.

  // Assert reset at a falling edge and hold it for n cycles.
  // Returns at the falling edge where rstn goes high again.
  task automatic apply_reset(input int n);
    @(negedge clock);
    rstn = 1'b0;
    repeat (n) @(negedge clock);
    rstn = 1'b1;
  endtask

  // Call between edges.
  // Presents the address until ready is seen, then drops valid.
  // On return it is 1 time unit after the handshake edge.
  task automatic drive_addr(input logic [31:0] a, output bit ok);
    ok = 1'b0;
    addr_r_addr_i  = a;
    addr_r_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (addr_r_ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (ok) begin
      @(posedge clock);
      #1;
    end
    addr_r_valid_i = 1'b0;
  endtask

  // Tests.

  task automatic test_reset;
    repeat (5) @(negedge clock);
    #1;
    total++; if (r_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", r_valid_o); end
    total++; if (r_last_o !== 1'b0) begin bad++; $display("FAIL rst_rlast: got %b want 0", r_last_o); end
    total++; if (addr_r_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", addr_r_ready_o); end
    total++; if (r_data_o !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", r_data_o); end
    total++; if (dut.mtime !== 64'h0) begin bad++; $display("FAIL rst_mtime: got %h want 0", dut.mtime); end
    @(negedge clock);
    rstn = 1'b1;
    #1;
    total++; if (addr_r_ready_o !== 1'b0) begin bad++; $display("FAIL rel_ready_early: got %b want 0", addr_r_ready_o); end
    @(posedge clock);
    #1;
    total++; if (addr_r_ready_o !== 1'b1) begin bad++; $display("FAIL rel_ready: got %b want 1", addr_r_ready_o); end
    total++; if (dbg_state_o !== 1'b0) begin bad++; $display("FAIL rel_state: got %b want 0", dbg_state_o); end
    total++; if (dut.mtime !== EXP_AFTER1) begin bad++; $display("FAIL rel_mtime: got %h want %h", dut.mtime, EXP_AFTER1); end
  endtask

  // Low-word read 100 cycles after release (T2).
  // It is followed directly by a backpressured read (T3).
  task automatic test_read_low_and_backpressure;
    bit ok;
    r_ready_i = 1'b1;
    apply_reset(3);
    repeat (100) @(posedge clock);
    @(negedge clock);
    drive_addr(LO_ADDR, ok);
    total++; if (!ok) begin bad++; $display("FAIL t2_hs_timeout: got no ready want ready"); end
    total++; if (r_valid_o !== 1'b1) begin bad++; $display("FAIL t2_rvalid: got %b want 1", r_valid_o); end
    total++; if (r_last_o !== 1'b1) begin bad++; $display("FAIL t2_rlast: got %b want 1", r_last_o); end
    total++; if (r_data_o !== EXP_T2) begin bad++; $display("FAIL t2_rdata: got %0d want %0d", r_data_o, EXP_T2); end
    total++; if (addr_r_ready_o !== 1'b0) begin bad++; $display("FAIL t2_ready_busy: got %b want 0", addr_r_ready_o); end
    @(posedge clock);
    #1;
    total++; if (r_valid_o !== 1'b0) begin bad++; $display("FAIL t2_rvalid_drop: got %b want 0", r_valid_o); end
    total++; if (addr_r_ready_o !== 1'b1) begin bad++; $display("FAIL t2_ready_back: got %b want 1", addr_r_ready_o); end

    // Backpressure: the handshake on the next edge captures 102.
    @(negedge clock);
    r_ready_i = 1'b0;
    drive_addr(LO_ADDR, ok);
    total++; if (!ok) begin bad++; $display("FAIL t3_hs_timeout: got no ready want ready"); end
    addr_r_addr_i = HI_ADDR;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      addr_r_valid_i = ~addr_r_valid_i;
      total++;
      if (r_valid_o !== 1'b1 || r_last_o !== 1'b1 || r_data_o !== EXP_T3 || addr_r_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL t3_hold[%0d]: got v=%b l=%b d=%0d rdy=%b want v=1 l=1 d=%0d rdy=0",
                 i, r_valid_o, r_last_o, r_data_o, addr_r_ready_o, EXP_T3);
      end
    end
    @(negedge clock);
    addr_r_valid_i = 1'b0;
    r_ready_i      = 1'b1;
    @(posedge clock);
    #1;
    total++; if (r_valid_o !== 1'b0 || addr_r_ready_o !== 1'b1) begin bad++; $display("FAIL t3_release: got v=%b rdy=%b want v=0 rdy=1", r_valid_o, addr_r_ready_o); end
    @(posedge clock);
    #1;
    total++; if (r_valid_o !== 1'b0 || dbg_state_o !== 1'b0) begin bad++; $display("FAIL t3_no_ghost: got v=%b st=%b want v=0 st=0", r_valid_o, dbg_state_o); end
  endtask

  // After the low read, the high read returns the shadow.
  // The live high word has already moved on by then.
  task automatic test_shadow;
    bit ok;
    r_ready_i = 1'b1;
    @(negedge clock);
    force dut.mtime = 64'h0000_0001_FFFF_FFFE;
    #1;
    release dut.mtime;
    drive_addr(LO_ADDR, ok);
    total++; if (!ok) begin bad++; $display("FAIL t4_lo_timeout: got no ready want ready"); end
    total++; if (r_data_o !== 32'hFFFF_FFFE) begin bad++; $display("FAIL t4_lo_data: got %h want fffffffe", r_data_o); end
    repeat (10) @(posedge clock);
    @(negedge clock);
    total++; if (dut.mtime[63:32] !== 32'h2) begin bad++; $display("FAIL t4_live_hi: got %h want 2", dut.mtime[63:32]); end
    drive_addr(HI_ADDR, ok);
    total++; if (!ok) begin bad++; $display("FAIL t4_hi_timeout: got no ready want ready"); end
    total++; if (r_data_o !== 32'h1 || r_valid_o !== 1'b1) begin bad++; $display("FAIL t4_hi_data: got %h v=%b want 00000001 v=1", r_data_o, r_valid_o); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_unmapped;
    bit ok;
    logic [31:0] addrs [2];
    addrs[0] = 32'h0200_0000;
    addrs[1] = 32'h0200_BFF9;
    r_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      drive_addr(addrs[i], ok);
      total++;
      if (!ok || r_data_o !== 32'h0 || r_valid_o !== 1'b1 || r_last_o !== 1'b1) begin
        bad++;
        $display("FAIL t5_read[%h]: got ok=%b d=%h v=%b l=%b want ok=1 d=0 v=1 l=1",
                 addrs[i], ok, r_data_o, r_valid_o, r_last_o);
      end
      @(posedge clock);
      #1;
      total++; if (r_valid_o !== 1'b0 || addr_r_ready_o !== 1'b1) begin bad++; $display("FAIL t5_done[%h]: got v=%b rdy=%b want v=0 rdy=1", addrs[i], r_valid_o, addr_r_ready_o); end
    end
  endtask

  // Prescaled count check, then a reset while a response is pending.
  task automatic test_prescale_and_reset;
    bit ok;
    r_ready_i = 1'b1;
    apply_reset(3);
    repeat (40) @(posedge clock);
    @(negedge clock);
    r_ready_i = 1'b0;
    drive_addr(LO_ADDR, ok);
    total++; if (!ok) begin bad++; $display("FAIL t6_hs_timeout: got no ready want ready"); end
    total++; if (r_data_o !== EXP_T6) begin bad++; $display("FAIL t6_rdata: got %0d want %0d", r_data_o, EXP_T6); end
    #2;
    rstn = 1'b0;
    #1;
    total++; if (r_valid_o !== 1'b0 || r_last_o !== 1'b0 || addr_r_ready_o !== 1'b0) begin bad++; $display("FAIL t6_async_rst: got v=%b l=%b rdy=%b want 0 0 0", r_valid_o, r_last_o, addr_r_ready_o); end
    total++; if (dut.mtime !== 64'h0) begin bad++; $display("FAIL t6_mtime_rst: got %h want 0", dut.mtime); end
    @(negedge clock);
    r_ready_i = 1'b1;
    rstn      = 1'b1;
    @(posedge clock);
    #1;
    total++; if (r_valid_o !== 1'b0 || addr_r_ready_o !== 1'b1) begin bad++; $display("FAIL t6_after_rst: got v=%b rdy=%b want v=0 rdy=1", r_valid_o, addr_r_ready_o); end
  endtask

  // Sequence and final report.
  initial begin
    rstn           = 1'b0;
    addr_r_addr_i  = 32'h0;
    addr_r_valid_i = 1'b0;
    r_ready_i      = 1'b0;
    test_reset();
    test_read_low_and_backpressure();
    test_shadow();
    test_unmapped();
    test_prescale_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
